// File: rtl/screen_scan_reader.sv
// Scans the 128x128 1-bpp screen RAM in step with the VGA timing and emits RGB565 pixels.
// Build with SCREEN_BLINK_EN defined to add the frame-based blink that inverts window pixels.
module screen_scan_reader #(
   parameter int unsigned WIN_X0       = 256,
   parameter int unsigned WIN_Y0       = 176,
   parameter logic [15:0] FG_COLOR     = 16'hFFFF,
   parameter logic [15:0] BG_COLOR     = 16'h0000,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ready,
   input  logic [10:0] x_cnt,
   input  logic [9:0]  y_cnt,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic        rd_en,
   output logic [10:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic        hsync,
   output logic        vsync,
   output logic [15:0] rgb
);

   logic [10:0] w_dx;
   logic [9:0]  w_dy;
   logic        w_in_win;
   logic        w_blink;

   logic        r_rd_en;
   logic [10:0] r_rd_addr;
   logic [2:0]  r_bit_p1;
   logic        r_win_p1;
   logic        r_vld_p1;
   logic [2:0]  r_bit_p2;
   logic        r_win_p2;
   logic        r_vld_p2;
   logic [15:0] r_rgb;
   logic [2:0]  r_hs_sr;
   logic [2:0]  r_vs_sr;

   function automatic logic [15:0] pixel_color(input logic vld, input logic win,
                                               input logic bit_set, input logic inv);
      if (!vld)
         return 16'h0000;
      if (!win)
         return BG_COLOR;
      return (bit_set ^ inv) ? FG_COLOR : BG_COLOR;
   endfunction

   // Stage 0: window test; unsigned wrap makes coordinates left of / above the window land out of range
   assign w_dx     = x_cnt - 11'(WIN_X0);
   assign w_dy     = y_cnt - 10'(WIN_Y0);
   assign w_in_win = ready & (w_dx < 11'd128) & (w_dy < 10'd128);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_bit_p1  <= '0;
         r_win_p1  <= 1'b0;
         r_vld_p1  <= 1'b0;
         r_bit_p2  <= '0;
         r_win_p2  <= 1'b0;
         r_vld_p2  <= 1'b0;
         r_rgb     <= '0;
         r_hs_sr   <= '1;
         r_vs_sr   <= '1;
      end else begin
         // Stage 1: issue RAM read, address = {row, byte within row}
         r_rd_en  <= w_in_win;
         if (w_in_win)
            r_rd_addr <= {w_dy[6:0], w_dx[6:3]};
         r_bit_p1 <= w_dx[2:0];
         r_win_p1 <= w_in_win;
         r_vld_p1 <= ready;
         // Stage 2: RAM data returns; side-band follows it
         r_bit_p2 <= r_bit_p1;
         r_win_p2 <= r_win_p1;
         r_vld_p2 <= r_vld_p1;
         // Stage 3: bit0 of each byte is the leftmost pixel
         r_rgb    <= pixel_color(r_vld_p2, r_win_p2, rd_data[r_bit_p2], w_blink);
         r_hs_sr  <= {r_hs_sr[1:0], hsync_in};
         r_vs_sr  <= {r_vs_sr[1:0], vsync_in};
      end
   end

`ifdef SCREEN_BLINK_EN
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic             r_vs_d;
   logic [CNT_W-1:0] r_frame_cnt;
   logic             r_blink;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_d      <= 1'b1;
         r_frame_cnt <= '0;
         r_blink     <= 1'b0;
      end else begin
         r_vs_d <= vsync_in;
         if (r_vs_d & ~vsync_in) begin
            if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
               r_frame_cnt <= '0;
               r_blink     <= ~r_blink;
            end else begin
               r_frame_cnt <= r_frame_cnt + 1'b1;
            end
         end
      end
   end

   assign w_blink = r_blink;
`else
   // Without the blink feature the inversion input is tied low.
   assign w_blink = (BLINK_FRAMES == 0) & 1'b0;
`endif

   assign rd_en   = r_rd_en;
   assign rd_addr = r_rd_addr;
   assign rgb     = r_rgb;
   assign hsync   = r_hs_sr[2];
   assign vsync   = r_vs_sr[2];

endmodule

// File: tb/tb_screen_scan_reader.sv
// Directed bench for screen_scan_reader with a behavioural synchronous screen RAM.
module tb_screen_scan_reader;

   localparam logic [15:0] TB_FG = 16'hF81F;
   localparam logic [15:0] TB_BG = 16'h07E0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ready = 1'b0;
   logic [10:0] x_cnt = '0;
   logic [9:0]  y_cnt = '0;
   logic        hsync_in = 1'b1;
   logic        vsync_in = 1'b1;
   logic        rd_en;
   logic [10:0] rd_addr;
   logic [7:0]  rd_data = 8'h00;
   logic        hsync;
   logic        vsync;
   logic [15:0] rgb;

   logic [7:0]  mem [0:2047];
   int          n_vec = 0;
   int          n_err = 0;

   screen_scan_reader #(
      .WIN_X0(256), .WIN_Y0(176), .FG_COLOR(TB_FG), .BG_COLOR(TB_BG), .BLINK_FRAMES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ready(ready), .x_cnt(x_cnt), .y_cnt(y_cnt),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .hsync(hsync), .vsync(vsync), .rgb(rgb)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (rd_en) rd_data <= mem[rd_addr];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic r, input int x, input int y);
      ready = r;
      x_cnt = 11'(x);
      y_cnt = 10'(y);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ready    = 1'($urandom);
         x_cnt    = 11'($urandom_range(0, 639));
         y_cnt    = 10'($urandom_range(0, 479));
         hsync_in = 1'($urandom);
         vsync_in = 1'($urandom);
         tick();
      end
      n_vec++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
      n_vec++; if (rd_addr !== 11'd0) begin n_err++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
      n_vec++; if (rgb !== 16'h0000) begin n_err++; $display("FAIL reset_rgb: got %h want 0000", rgb); end
      n_vec++; if (hsync !== 1'b1) begin n_err++; $display("FAIL reset_hsync: got %b want 1", hsync); end
      n_vec++; if (vsync !== 1'b1) begin n_err++; $display("FAIL reset_vsync: got %b want 1", vsync); end
      drv(0, 0, 0);
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      #3 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++;
         if (rd_en !== 1'b0 || rd_addr !== 11'd0 || rgb !== 16'h0000 || hsync !== 1'b1 || vsync !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_idle[%0d]: got en=%b addr=%0d rgb=%h hs=%b vs=%b want 0 0 0000 1 1",
                     i, rd_en, rd_addr, rgb, hsync, vsync);
         end
      end
   endtask

   task automatic test_top_left;
      drv(1, 256, 176);
      tick();
      n_vec++; if (rd_en !== 1'b1 || rd_addr !== 11'd0) begin n_err++;
         $display("FAIL tl_addr: got en=%b addr=%0d want en=1 addr=0", rd_en, rd_addr); end
      drv(1, 257, 176);
      tick();
      n_vec++; if (rgb !== 16'h0000) begin n_err++; $display("FAIL tl_latency: got %h want 0000 at +2", rgb); end
      drv(1, 260, 176);
      tick();
      n_vec++; if (rgb !== TB_FG) begin n_err++; $display("FAIL tl_px0: got %h want %h", rgb, TB_FG); end
      drv(0, 0, 0);
      tick();
      n_vec++; if (rgb !== TB_BG) begin n_err++; $display("FAIL tl_px1: got %h want %h", rgb, TB_BG); end
      tick();
      n_vec++; if (rgb !== TB_BG) begin n_err++; $display("FAIL tl_px4: got %h want %h", rgb, TB_BG); end
      tick();
      n_vec++; if (rgb !== 16'h0000) begin n_err++; $display("FAIL tl_blank: got %h want 0000", rgb); end
   endtask

   task automatic test_right_border;
      drv(1, 383, 177);
      tick();
      n_vec++; if (rd_en !== 1'b1 || rd_addr !== 11'd31) begin n_err++;
         $display("FAIL rb_addr: got en=%b addr=%0d want en=1 addr=31", rd_en, rd_addr); end
      drv(1, 384, 177);
      tick();
      n_vec++; if (rd_en !== 1'b0 || rd_addr !== 11'd31) begin n_err++;
         $display("FAIL rb_outside: got en=%b addr=%0d want en=0 addr=31", rd_en, rd_addr); end
      drv(0, 0, 0);
      tick();
      n_vec++; if (rgb !== TB_FG) begin n_err++; $display("FAIL rb_px127: got %h want %h", rgb, TB_FG); end
      tick();
      n_vec++; if (rgb !== TB_BG) begin n_err++; $display("FAIL rb_px128: got %h want %h", rgb, TB_BG); end
      tick();
   endtask

   task automatic test_last_address;
      drv(1, 383, 303);
      tick();
      n_vec++; if (rd_en !== 1'b1 || rd_addr !== 11'd2047) begin n_err++;
         $display("FAIL la_addr: got en=%b addr=%0d want en=1 addr=2047", rd_en, rd_addr); end
      drv(1, 383, 304);
      tick();
      n_vec++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL la_below_en: got %b want 0", rd_en); end
      drv(1, 255, 176);
      tick();
      n_vec++; if (rgb !== TB_FG) begin n_err++; $display("FAIL la_px: got %h want %h", rgb, TB_FG); end
      n_vec++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL la_left_en: got %b want 0", rd_en); end
      drv(1, 256, 175);
      tick();
      n_vec++; if (rgb !== TB_BG) begin n_err++; $display("FAIL la_below_rgb: got %h want %h", rgb, TB_BG); end
      n_vec++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL la_above_en: got %b want 0", rd_en); end
      drv(0, 0, 0);
      tick();
      n_vec++; if (rgb !== TB_BG) begin n_err++; $display("FAIL la_left_rgb: got %h want %h", rgb, TB_BG); end
      tick();
      n_vec++; if (rgb !== TB_BG) begin n_err++; $display("FAIL la_above_rgb: got %h want %h", rgb, TB_BG); end
      tick();
   endtask

   task automatic test_sync;
      logic [13:0] hpat;
      logic [13:0] vpat;
      logic        hexp;
      logic        vexp;
      hpat = 14'b11111100001111;
      vpat = 14'b11110011111111;
      drv(0, 0, 0);
      for (int i = 0; i < 14; i++) begin
         hsync_in = hpat[13 - i];
         vsync_in = vpat[13 - i];
         tick();
         hexp = (i >= 2) ? hpat[15 - i] : 1'b1;
         vexp = (i >= 2) ? vpat[15 - i] : 1'b1;
         n_vec++;
         if (hsync !== hexp || vsync !== vexp || rgb !== 16'h0000) begin
            n_err++;
            $display("FAIL sync[%0d]: got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=0000",
                     i, hsync, vsync, rgb, hexp, vexp);
         end
      end
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_async_reset;
      drv(1, 383, 303);
      repeat (3) tick();
      n_vec++; if (rgb !== TB_FG || rd_addr !== 11'd2047) begin n_err++;
         $display("FAIL ar_pre: got rgb=%h addr=%0d want %h 2047", rgb, rd_addr, TB_FG); end
      hsync_in = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (rgb !== 16'h0000 || rd_en !== 1'b0 || rd_addr !== 11'd0 || hsync !== 1'b1) begin
         n_err++;
         $display("FAIL ar_immediate: got rgb=%h en=%b addr=%0d hs=%b want 0000 0 0 1", rgb, rd_en, rd_addr, hsync);
      end
      drv(0, 0, 0);
      hsync_in = 1'b1;
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (rgb !== 16'h0000) begin n_err++; $display("FAIL ar_dropped[%0d]: got %h want 0000", i, rgb); end
      end
      drv(1, 256, 176);
      tick();
      drv(0, 0, 0);
      tick();
      n_vec++; if (rgb !== 16'h0000) begin n_err++; $display("FAIL ar_first_early: got %h want 0000", rgb); end
      tick();
      n_vec++; if (rgb !== TB_FG) begin n_err++; $display("FAIL ar_first: got %h want %h", rgb, TB_FG); end
      tick();
   endtask

`ifdef SCREEN_BLINK_EN
   task automatic vs_edges(input int n);
      for (int i = 0; i < n; i++) begin
         vsync_in = 1'b0;
         repeat (2) tick();
         vsync_in = 1'b1;
         repeat (2) tick();
      end
   endtask

   task automatic blink_pair(input logic [15:0] e0, input logic [15:0] e1, input string tag);
      drv(1, 256, 176);
      tick();
      drv(1, 257, 176);
      tick();
      drv(1, 384, 176);
      tick();
      n_vec++; if (rgb !== e0) begin n_err++; $display("FAIL %s_px0: got %h want %h", tag, rgb, e0); end
      drv(0, 0, 0);
      tick();
      n_vec++; if (rgb !== e1) begin n_err++; $display("FAIL %s_px1: got %h want %h", tag, rgb, e1); end
      tick();
      n_vec++; if (rgb !== TB_BG) begin n_err++; $display("FAIL %s_outside: got %h want %h", tag, rgb, TB_BG); end
      tick();
      n_vec++; if (rgb !== 16'h0000) begin n_err++; $display("FAIL %s_blank: got %h want 0000", tag, rgb); end
   endtask

   task automatic test_blink;
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      vs_edges(1);
      blink_pair(TB_FG, TB_BG, "blink_one_edge");
      vs_edges(1);
      blink_pair(TB_BG, TB_FG, "blink_on");
      vs_edges(2);
      blink_pair(TB_FG, TB_BG, "blink_off");
   endtask
`endif

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      mem[0]    = 8'h01;
      mem[31]   = 8'h80;
      mem[2047] = 8'hFF;
      test_reset();
      test_top_left();
      test_right_border();
      test_last_address();
      test_sync();
      test_async_reset();
`ifdef SCREEN_BLINK_EN
      test_blink();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/screen_scan_reader.md
Name: screen_scan_reader

Overview:
- Read-side counterpart of the screen RAM writers: scans the 2048-byte, 1-bpp screen RAM (128x128 pixels, 16 bytes per row) in step with the VGA sync generator.
- Converts each stored bit into an RGB565 pixel inside a 128x128 window placed on the 640x480 active area.
- Sits between the sync generator, the read port of the dual-port screen RAM, and the VGA output pins.
- Re-times hsync/vsync so they stay aligned with the pixel pipeline.

Parameters:
- WIN_X0, 256, active-area column of the window's left edge.
- WIN_Y0, 176, active-area row of the window's top edge.
- FG_COLOR, 16'hFFFF, RGB565 colour for a set bit.
- BG_COLOR, 16'h0000, RGB565 colour for a clear bit and for the area outside the window inside the active region.
- BLINK_FRAMES, 30, frames per blink half-period (optional feature only).

Ports:
- clk  input  1  pixel clock.
- rst_n  input  1  asynchronous active-low reset.
- ready  input  1  sync generator's active-video flag, valid with x_cnt/y_cnt.
- x_cnt  input  11  active-area column, 0..639, meaningful when ready=1.
- y_cnt  input  10  active-area row, 0..479, meaningful when ready=1.
- hsync_in  input  1  raw hsync from the generator (active low).
- vsync_in  input  1  raw vsync from the generator (active low).
- rd_en  output  1  screen RAM read enable.
- rd_addr  output  11  screen RAM read address.
- rd_data  input  8  screen RAM read data, valid one clk after rd_addr/rd_en (synchronous RAM).
- hsync  output  1  delayed hsync.
- vsync  output  1  delayed vsync.
- rgb  output  16  RGB565 pixel.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, rgb=0, hsync=1, vsync=1. All pipeline registers are cleared; the sync delay taps are set to 1.
- Reset is asynchronous. Asserting it mid-frame drops all in-flight pixels immediately. After release, the first valid rgb appears 3 clk after the next ready=1 sample.
- Stage 0 (combinational on the inputs):
  - in_win = ready & (x_cnt - WIN_X0) < 128 & (y_cnt - WIN_Y0) < 128, using unsigned 11/10-bit subtraction so underflow falls outside the window.
  - col = x_cnt - WIN_X0, low 7 bits.
  - row = y_cnt - WIN_Y0, low 7 bits.
- Stage 1 (registered):
  - rd_en <= in_win.
  - rd_addr <= {row[6:0], col[6:3]} when in_win; otherwise rd_addr holds its value.
  - The stage also registers bit_idx = col[2:0], in_win, and ready.
- Stage 2: rd_data is returned by the RAM. bit_idx, in_win, and ready are delayed one more clk alongside it.
- Stage 3 (registered):
  - rgb <= 0 when the delayed ready = 0.
  - Otherwise rgb <= BG_COLOR when the delayed in_win = 0.
  - Otherwise rgb <= (rd_data[bit_idx] ? FG_COLOR : BG_COLOR).
- Bit order: bit0 is the leftmost pixel of each byte. Byte value 8'h01 lights column 0; 8'h80 lights column 7.
- Latency: rgb for coordinate (x,y) appears exactly 3 clk after that coordinate is presented. hsync/vsync pass through a 3-stage shift register, so they carry the same 3 clk delay.
- Address wrap: col/row span 0..127, so rd_addr covers 0..2047 exactly with no overflow. The last window pixel (x=WIN_X0+127, y=WIN_Y0+127) reads address 2047.
- No back-pressure: one pixel is accepted per clk unconditionally. The RAM write port is independent, and a read/write collision on the same address returns whatever the RAM's read-during-write rule gives, with no arbitration in this block.

Optional Feature:
- Macro: SCREEN_BLINK_EN.
- Defined:
  - A frame counter increments on each falling edge of vsync_in, as detected by a registered copy.
  - On reaching BLINK_FRAMES-1 the counter wraps to 0 and toggles a blink flag. The counter and flag reset to 0.
  - While blink=1, window pixels swap colours: set bits render BG_COLOR, clear bits render FG_COLOR.
  - Outside-window and blanking pixels are unchanged. Latency stays at 3 clk.
- Undefined: no counter logic; window pixels are never inverted.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> rd_en=0, rd_addr=0, rgb=0, hsync=vsync=1. Release -> outputs stay at those values until ready=1 is presented.
- Top-left pixel: ready=1, x=256, y=176, RAM byte 0 = 8'h01 -> rd_en=1, rd_addr=0 at +1 clk; rgb=16'hFFFF at +3 clk. x=257 -> rgb=16'h0000.
- Right border: x=383, y=177, byte 31 = 8'h80 -> rd_addr=31; rgb=FG_COLOR at +3 clk. x=384 -> rd_en=0; rgb=BG_COLOR.
- Last address: x=383, y=303, byte 2047 = 8'hFF -> rd_addr=2047; rgb=FG_COLOR. y=304 -> rgb=BG_COLOR.
- Blanking/sync: ready=0 with a hsync_in low pulse -> rgb=0; hsync goes low exactly 3 clk after hsync_in and keeps the same pulse width.
- SCREEN_BLINK_EN, BLINK_FRAMES=2: after 2 vsync_in falling edges, byte 0 = 8'h01 at (256,176) -> rgb=BG_COLOR and (257,176) -> rgb=FG_COLOR. After 2 more edges the colours return to normal.
